// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch: FSM states, the hh:mm:ss word,
// and the one-second advance of that word.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        SW_IDLE  = 2'd0,
        SW_RUN   = 2'd1,
        SW_PAUSE = 2'd2
    } sw_state_t;

    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
    } hms_t;

    localparam logic [7:0] SEC_MAX  = 8'd59;
    localparam logic [7:0] MIN_MAX  = 8'd59;
    localparam logic [7:0] HOUR_MAX = 8'd23;

    // Advance by one second; 23:59:59 rolls over to 00:00:00
    function automatic hms_t hms_next(input hms_t t);
        hms_t n;
        n = t;
        if (t.ss != SEC_MAX) begin
            n.ss = t.ss + 8'd1;
        end else begin
            n.ss = 8'd0;
            if (t.mm != MIN_MAX) begin
                n.mm = t.mm + 8'd1;
            end else begin
                n.mm = 8'd0;
                n.hh = (t.hh == HOUR_MAX) ? 8'd0 : t.hh + 8'd1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/lap_fifo.sv
// First-word fall-through FIFO with registered head/flags and a synchronous flush.
// Push into a full FIFO is only accepted when a pop happens in the same cycle.
module lap_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             flush,
    input  logic                             push,
    input  logic                             pop,
    input  logic [WIDTH-1:0]                 wr_data,
    output logic [WIDTH-1:0]                 rd_data,
    output logic                             valid,
    output logic                             empty,
    output logic                             full,
    output logic [$clog2(DEPTH+1)-1:0]       count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
    logic [CNT_W-1:0] count_next;
    logic [WIDTH-1:0] head_next;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next pointers, occupancy and head word; a pop into the only entry with a
    // simultaneous push falls through to the incoming word
    always_comb begin
        do_pop      = pop && (count != '0);
        do_push     = push && (!full || do_pop);
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        count_next  = count;
        head_next   = rd_data;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
            head_next   = '0;
        end else begin
            if (do_push) wr_ptr_next = ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr_next = ptr_inc(rd_ptr);
            count_next = count + CNT_W'(do_push) - CNT_W'(do_pop);
            if (count_next == '0)
                head_next = '0;
            else if (do_pop)
                head_next = (count == CNT_W'(1)) ? wr_data : mem[rd_ptr_next];
            else if (count == '0)
                head_next = wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
            valid   <= 1'b0;
            empty   <= 1'b1;
            full    <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_next;
            rd_ptr  <= rd_ptr_next;
            count   <= count_next;
            rd_data <= head_next;
            valid   <= (count_next != '0);
            empty   <= (count_next == '0);
            full    <= (count_next == CNT_W'(DEPTH));
        end
    end

endmodule

// File: rtl/lap_stopwatch.sv
// Start/pause/resume stopwatch with hh:mm:ss output and a lap-time FIFO.
// Buttons are honoured only in the active UI mode; lap readout works in any mode.
module lap_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned LAP_DEPTH   = 4,
    parameter logic [1:0]  ACTIVE_MODE = 2'd2
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [1:0]                       rezhim,
    input  logic                             btn_start_stop,
    input  logic                             btn_reset,
    input  logic                             btn_lap,
    input  logic                             lap_rd,
    output logic [23:0]                      data_s,
    output logic                             running,
    output logic [23:0]                      lap_data,
    output logic                             lap_valid,
    output logic [$clog2(LAP_DEPTH+1)-1:0]   lap_count,
    output logic                             lap_overflow
);

    localparam int unsigned PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);

    sw_state_t        state, state_next;
    logic [PRE_W-1:0] presc;
    hms_t             time_q;
    logic             clr_c, toggle_c, lap_push_c, tick_c;
    logic             fifo_full, fifo_empty;

    assign data_s = time_q;

    // Mode-gated button decode; clear outranks every other button
    always_comb begin
        clr_c      = (rezhim == ACTIVE_MODE) && btn_reset;
        toggle_c   = (rezhim == ACTIVE_MODE) && btn_start_stop && !btn_reset;
        lap_push_c = (rezhim == ACTIVE_MODE) && btn_lap && !btn_reset && (state == SW_RUN);
        tick_c     = (state == SW_RUN) && (presc == PRE_LAST);
    end

    always_comb begin
        state_next = state;
        if (clr_c) begin
            state_next = SW_IDLE;
        end else if (toggle_c) begin
            unique case (state)
                SW_IDLE:  state_next = SW_RUN;
                SW_RUN:   state_next = SW_PAUSE;
                SW_PAUSE: state_next = SW_RUN;
                default:  state_next = SW_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= SW_IDLE;
            running <= 1'b0;
        end else begin
            state   <= state_next;
            running <= (state_next == SW_RUN);
        end
    end

    // Prescaler holds in pause so the fractional second survives a resume
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc        <= '0;
            time_q       <= '0;
            lap_overflow <= 1'b0;
        end else if (clr_c) begin
            presc        <= '0;
            time_q       <= '0;
            lap_overflow <= 1'b0;
        end else begin
            if (state == SW_RUN) begin
                presc <= tick_c ? '0 : presc + PRE_W'(1);
                if (tick_c) time_q <= hms_next(time_q);
            end
            if (lap_push_c && fifo_full && !(lap_rd && !fifo_empty))
                lap_overflow <= 1'b1;
        end
    end

    lap_fifo #(
        .WIDTH (24),
        .DEPTH (LAP_DEPTH)
    ) u_lap_fifo (
        .clock   (clock),
        .reset   (reset),
        .flush   (clr_c),
        .push    (lap_push_c),
        .pop     (lap_rd),
        .wr_data (time_q),
        .rd_data (lap_data),
        .valid   (lap_valid),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (lap_count)
    );

endmodule

// File: tb/tb_lap_stopwatch.sv
// Directed bench for lap_stopwatch: a CLK_HZ=4 instance for most scenarios and
// a CLK_HZ=1 instance for the full-day rollover.
module tb_lap_stopwatch;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  rezhim = 2'd2;
    logic        btn_start_stop = 1'b0, btn_reset = 1'b0, btn_lap = 1'b0, lap_rd = 1'b0;
    logic [23:0] data_s, lap_data;
    logic        running, lap_valid, lap_overflow;
    logic [2:0]  lap_count;

    logic        h_start = 1'b0;
    logic [1:0]  h_rezhim = 2'd2;
    logic        h_zero = 1'b0;
    logic [23:0] h_data_s, h_lap_data;
    logic        h_running, h_lap_valid, h_lap_overflow;
    logic [2:0]  h_lap_count;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    lap_stopwatch #(.CLK_HZ(4), .LAP_DEPTH(4), .ACTIVE_MODE(2'd2)) u_dut (
        .clock          (clock),
        .reset          (reset),
        .rezhim         (rezhim),
        .btn_start_stop (btn_start_stop),
        .btn_reset      (btn_reset),
        .btn_lap        (btn_lap),
        .lap_rd         (lap_rd),
        .data_s         (data_s),
        .running        (running),
        .lap_data       (lap_data),
        .lap_valid      (lap_valid),
        .lap_count      (lap_count),
        .lap_overflow   (lap_overflow)
    );

    lap_stopwatch #(.CLK_HZ(1), .LAP_DEPTH(4), .ACTIVE_MODE(2'd2)) u_hz1 (
        .clock          (clock),
        .reset          (reset),
        .rezhim         (h_rezhim),
        .btn_start_stop (h_start),
        .btn_reset      (h_zero),
        .btn_lap        (h_zero),
        .lap_rd         (h_zero),
        .data_s         (h_data_s),
        .running        (h_running),
        .lap_data       (h_lap_data),
        .lap_valid      (h_lap_valid),
        .lap_count      (h_lap_count),
        .lap_overflow   (h_lap_overflow)
    );

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Raise the requested buttons for exactly one rising edge; called at a negedge
    task automatic press(input logic s, input logic r, input logic l, input logic rd);
        btn_start_stop = s;
        btn_reset      = r;
        btn_lap        = l;
        lap_rd         = rd;
        @(negedge clock);
        btn_start_stop = 1'b0;
        btn_reset      = 1'b0;
        btn_lap        = 1'b0;
        lap_rd         = 1'b0;
    endtask

    task automatic test_reset;
        press(1'b1, 1'b0, 1'b0, 1'b0);
        wait_cycles(9);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (lap_count !== 3'd1) begin errors++; $display("FAIL pre_reset_lap_count got %0d want 1", lap_count); end
        #2 reset = 1'b1;
        @(negedge clock);
        checks++;
        if (data_s !== 24'h0) begin errors++; $display("FAIL reset_data_s got %h want 000000", data_s); end
        checks++;
        if ({running, lap_valid, lap_count, lap_overflow} !== 6'b0)
            begin errors++; $display("FAIL reset_flags got run=%b val=%b cnt=%0d ovf=%b want all 0", running, lap_valid, lap_count, lap_overflow); end
        reset = 1'b0;
        wait_cycles(1);
    endtask

    task automatic test_count;
        press(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (running !== 1'b1) begin errors++; $display("FAIL start_running got %b want 1", running); end
        wait_cycles(243);
        checks++;
        if (data_s !== 24'h000100) begin errors++; $display("FAIL count_243 got %h want 000100", data_s); end
        wait_cycles(1);
        checks++;
        if (data_s !== 24'h000101) begin errors++; $display("FAIL count_244 got %h want 000101", data_s); end
        press(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (data_s !== 24'h0 || running !== 1'b0)
            begin errors++; $display("FAIL btn_reset_clear got %h run=%b want 000000 run=0", data_s, running); end
    endtask

    task automatic test_pause;
        press(1'b1, 1'b0, 1'b0, 1'b0);
        wait_cycles(5);
        checks++;
        if (data_s !== 24'h000001) begin errors++; $display("FAIL pause_pre got %h want 000001", data_s); end
        press(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (running !== 1'b0) begin errors++; $display("FAIL pause_running got %b want 0", running); end
        wait_cycles(100);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (data_s !== 24'h000001 || lap_count !== 3'd0)
            begin errors++; $display("FAIL pause_hold got %h laps=%0d want 000001 laps=0", data_s, lap_count); end
        press(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (running !== 1'b1 || data_s !== 24'h000001)
            begin errors++; $display("FAIL resume got run=%b %h want run=1 000001", running, data_s); end
        wait_cycles(1);
        checks++;
        if (data_s !== 24'h000001) begin errors++; $display("FAIL resume_plus1 got %h want 000001", data_s); end
        wait_cycles(1);
        checks++;
        if (data_s !== 24'h000002) begin errors++; $display("FAIL resume_plus2 got %h want 000002", data_s); end
        press(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_laps;
        press(1'b1, 1'b0, 1'b0, 1'b0);
        wait_cycles(5);
        for (int i = 0; i < 5; i++) begin
            press(1'b0, 1'b0, 1'b1, 1'b0);
            if (i == 0) begin
                checks++;
                if (lap_valid !== 1'b1 || lap_data !== 24'h000001)
                    begin errors++; $display("FAIL first_lap got val=%b %h want val=1 000001", lap_valid, lap_data); end
            end
            if (i < 4) wait_cycles(3);
        end
        checks++;
        if (lap_count !== 3'd4 || lap_overflow !== 1'b1)
            begin errors++; $display("FAIL lap_full got cnt=%0d ovf=%b want cnt=4 ovf=1", lap_count, lap_overflow); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (lap_data !== 24'(i + 1))
                begin errors++; $display("FAIL lap_read_%0d got %h want %h", i, lap_data, 24'(i + 1)); end
            press(1'b0, 1'b0, 1'b0, 1'b1);
        end
        checks++;
        if (lap_valid !== 1'b0 || lap_count !== 3'd0 || lap_data !== 24'h0)
            begin errors++; $display("FAIL lap_drained got val=%b cnt=%0d %h want 0 0 000000", lap_valid, lap_count, lap_data); end
        checks++;
        if (lap_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", lap_overflow); end
        press(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (lap_overflow !== 1'b0) begin errors++; $display("FAIL ovf_cleared got %b want 0", lap_overflow); end
    endtask

    task automatic test_mode;
        rezhim = 2'd1;
        press(1'b1, 1'b0, 1'b0, 1'b0);
        wait_cycles(8);
        checks++;
        if (running !== 1'b0 || data_s !== 24'h0)
            begin errors++; $display("FAIL gated_start got run=%b %h want run=0 000000", running, data_s); end
        rezhim = 2'd2;
        press(1'b1, 1'b0, 1'b0, 1'b0);
        wait_cycles(7);
        rezhim = 2'd1;
        press(1'b0, 1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (running !== 1'b1 || data_s !== 24'h000002 || lap_count !== 3'd0)
            begin errors++; $display("FAIL gated_buttons got run=%b %h laps=%0d want run=1 000002 laps=0", running, data_s, lap_count); end
        rezhim = 2'd2;
        press(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (running !== 1'b0 || data_s !== 24'h0)
            begin errors++; $display("FAIL reset_priority got run=%b %h want run=0 000000", running, data_s); end
        wait_cycles(6);
        checks++;
        if (running !== 1'b0 || data_s !== 24'h0)
            begin errors++; $display("FAIL reset_priority_idle got run=%b %h want run=0 000000", running, data_s); end
    endtask

    task automatic test_day_wrap;
        h_start = 1'b1;
        @(negedge clock);
        h_start = 1'b0;
        wait_cycles(86399);
        checks++;
        if (h_data_s !== 24'h173B3B) begin errors++; $display("FAIL hz1_235959 got %h want 173b3b", h_data_s); end
        wait_cycles(1);
        checks++;
        if (h_data_s !== 24'h0) begin errors++; $display("FAIL hz1_wrap got %h want 000000", h_data_s); end
        wait_cycles(1);
        checks++;
        if (h_data_s !== 24'h000001) begin errors++; $display("FAIL hz1_after_wrap got %h want 000001", h_data_s); end
    endtask

    initial begin
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(1);
        test_reset;
        test_count;
        test_pause;
        test_laps;
        test_mode;
        test_day_wrap;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
